tap_scan_mux: RTL and testbench
===============================

Name: tap_scan_mux

Overview:
Parametrised, registered N-to-1 tap selector for the RACE filter datapath; successor to the fixed 15-input combinational mux.
Two modes:
- Direct: single requested word at an external select.
- Auto-scan: walks all N channels in order, one word per beat, for the serial MAC.
The output stage uses a Valid/Ready handshake with back-pressure.

Parameters:
SIZE, 16, data word width in bits
N, 15, number of input channels (2..256)
SEL_W, $clog2(N), select/index width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Mode  in  1  0 = direct, 1 = auto-scan; sampled only when a request/start is accepted
Req  in  1  direct-mode request: capture channel Sel
Sel  in  SEL_W  direct-mode channel index
Start  in  1  auto-scan start pulse
A  in  N*SIZE  packed channel inputs; channel k = A[k*SIZE +: SIZE]
Ready  in  1  downstream accepts B this cycle
B  out  SIZE  registered selected word
Idx  out  SEL_W  channel index of word on B
Valid  out  1  B/Idx valid
Last  out  1  B is final beat of a scan (qualifies Valid)
Busy  out  1  scan in progress
Done  out  1  one-cycle pulse after final scan beat accepted

Behaviour:
- Reset (async, any time, including mid-scan): B=0, Idx=0, Valid=0, Last=0, Busy=0, Done=0, FSM=IDLE, counter=0. No partial scan resumes.
- Output slot free when !Valid || Ready; beat accepted when Valid && Ready.
- Stall: while Valid && !Ready, B/Idx/Last hold and the counter does not advance.
- FSM states: IDLE, SCAN.
- IDLE, Req=1, Mode=0, slot free: capture B <= A[Sel], Idx <= Sel, Valid=1 next cycle (latency 1). Last=0.
- Direct mode with Sel >= N: B=0, Idx=Sel, Valid still asserted.
- IDLE, Start=1, Mode=1: go to SCAN, Busy=1 next cycle, counter=0. Start wins over Req if both are high.
- SCAN, slot free: load A[cnt], Idx=cnt, Valid=1, Last=(cnt==N-1); then cnt increments.
- After loading cnt==N-1: stop loading. When that beat is accepted:
  - FSM goes to IDLE; Busy drops and Done pulses on the next cycle.
- SCAN ignores Start, Req, Sel and Mode. A Start coincident with the final acceptance is ignored.
- Back-to-back throughput: one beat per cycle with Ready held high. Full scan: N beats, first Valid one cycle after Start.
- A is sampled at load time, not at Start. The upstream holds taps stable for the scan.
- Counter never wraps: it saturates at N-1 until the FSM returns to IDLE.

Optional Feature:
Macro TAP_SCAN_ERR_EN.
- Defined: adds output SelErr (1 bit, reset 0). SelErr is registered alongside B and set for a direct-mode capture with Sel >= N; it is cleared on the next capture.
- Undefined: no SelErr port. Out-of-range select silently yields B=0, matching legacy mux behaviour.

Decomposition:
- Package tap_mux_pkg holds:
  - the state enum (IDLE, SCAN);
  - localparam function for SEL_W;
  - default SIZE/N constants shared with the filter top.
- One sub-module, tap_mux_comb:
  - purely combinational parametrised N-to-1 select from the packed bus;
  - zero for out-of-range index;
  - replaces the fixed 15-input mux elsewhere.

Test Plan:
- Reset then idle, A[k]=16'h0100+k: no Req/Start -> Valid=0, B=0, Busy=0 for 10 cycles.
- Direct, Req=1, Sel=5, Ready=1 -> next cycle B=16'h0105, Idx=5, Valid=1, Last=0. Sel=15 with N=15 -> B=0, plus SelErr=1 when TAP_SCAN_ERR_EN is defined.
- Scan, Start with Mode=1, Ready=1 -> B=0x0100..0x010E on 15 consecutive cycles. Last=1 only on Idx=14. Done pulses the cycle after that beat; Busy is low afterwards.
- Back-pressure: Ready=0 for 3 cycles at Idx=7 -> B=0x0107 held, no index skipped or repeated, total scan 18 cycles.
- Async rst asserted mid-scan at Idx=9 -> all outputs 0 immediately. A new Start after release restarts at Idx=0.
- Start pulsed during SCAN, and coincident with final acceptance -> ignored. Only one scan of exactly 15 beats and one Done pulse occur.

Source files
------------

// File: rtl/tap_mux_pkg.sv
// Shared types and constants for the RACE filter tap selector.
// Holds the scan FSM state type and the select-width helper.
package tap_mux_pkg;

    localparam int DEFAULT_SIZE = 16;
    localparam int DEFAULT_N    = 15;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    // A single-bit select is still needed when N is 1 or 2.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tap_mux_comb.sv
// Combinational N-to-1 word select from a packed channel bus.
// An index at or beyond N selects zero, matching the legacy fixed mux.
module tap_mux_comb
    import tap_mux_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N*SIZE-1:0] a,
    input  logic [SEL_W-1:0]  sel,
    output logic [SIZE-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                y = a[k*SIZE +: SIZE];
            end
        end
    end

endmodule

// File: rtl/tap_scan_mux.sv
// Registered N-to-1 tap selector with direct and auto-scan modes and a Valid/Ready output.
// Define TAP_SCAN_ERR_EN to add the SelErr flag for out-of-range direct selects.
module tap_scan_mux
    import tap_mux_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = sel_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Mode,
    input  logic              Req,
    input  logic [SEL_W-1:0]  Sel,
    input  logic              Start,
    input  logic [N*SIZE-1:0] A,
    input  logic              Ready,
    output logic [SIZE-1:0]   B,
    output logic [SEL_W-1:0]  Idx,
    output logic              Valid,
    output logic              Last,
    output logic              Busy,
    output logic              Done
`ifdef TAP_SCAN_ERR_EN
    ,
    output logic              SelErr
`endif
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    scan_state_t      state, nextState;
    logic [SEL_W-1:0] cnt, nextCnt, loadIdx;
    logic [SIZE-1:0]  word;
    logic             doLoad, loadLast, scanEnd, slotFree, accept;

    assign slotFree = !Valid || Ready;
    assign accept   = Valid && Ready;
    assign Busy     = (state == SCAN);

    tap_mux_comb #(
        .SIZE  (SIZE),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_mux (
        .a   (A),
        .sel (loadIdx),
        .y   (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // cnt is the next channel to load; a Start into a free slot loads channel 0 at once.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        doLoad    = 1'b0;
        loadIdx   = Sel;
        loadLast  = 1'b0;
        scanEnd   = 1'b0;
        case (state)
            IDLE: begin
                if (Start && Mode) begin
                    nextState = SCAN;
                    nextCnt   = '0;
                    if (slotFree) begin
                        doLoad  = 1'b1;
                        loadIdx = '0;
                        nextCnt = SEL_W'(1);
                    end
                end else if (Req && !Mode && slotFree) begin
                    doLoad = 1'b1;
                end
            end
            SCAN: begin
                if (accept && Last) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                    scanEnd   = 1'b1;
                end else if (slotFree && !(Valid && Last)) begin
                    doLoad   = 1'b1;
                    loadIdx  = cnt;
                    loadLast = (cnt == LAST_IDX);
                    nextCnt  = (cnt == LAST_IDX) ? cnt : cnt + SEL_W'(1);
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output slot: holds its word while stalled, empties when a beat leaves with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            B     <= '0;
            Idx   <= '0;
            Valid <= 1'b0;
            Last  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= scanEnd;
            if (doLoad) begin
                B     <= word;
                Idx   <= loadIdx;
                Valid <= 1'b1;
                Last  <= loadLast;
            end else if (accept) begin
                Valid <= 1'b0;
                Last  <= 1'b0;
            end
        end
    end

`ifdef TAP_SCAN_ERR_EN
    // In IDLE a load with Mode low is always a direct capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SelErr <= 1'b0;
        end else if (doLoad) begin
            SelErr <= (state == IDLE) && !Mode && (32'(Sel) >= N);
        end
    end
`endif

endmodule

// File: tb/tb_tap_scan_mux.sv
// Randomised scoreboard bench for tap_scan_mux: expected beats are queued at issue time
// and a monitor checks every accepted beat against a channel-array reference model.
module tb_tap_scan_mux;

    localparam int SIZE  = 16;
    localparam int N     = 15;
    localparam int SEL_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              Mode, Req, Start, Ready;
    logic [SEL_W-1:0]  Sel;
    logic [N*SIZE-1:0] A;
    logic [SIZE-1:0]   B;
    logic [SEL_W-1:0]  Idx;
    logic              Valid, Last, Busy, Done;
`ifdef TAP_SCAN_ERR_EN
    logic              SelErr;
`endif

    typedef struct {
        logic [SIZE-1:0] b;
        int              idx;
        bit              last;
        bit              err;
    } beat_t;

    logic [SIZE-1:0] taps [N];
    beat_t           sb[$];
    beat_t           monBeat;
    int              vectors     = 0;
    int              miscompares = 0;

    tap_scan_mux #(.SIZE(SIZE), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .Mode  (Mode),
        .Req   (Req),
        .Sel   (Sel),
        .Start (Start),
        .A     (A),
        .Ready (Ready),
        .B     (B),
        .Idx   (Idx),
        .Valid (Valid),
        .Last  (Last),
        .Busy  (Busy),
        .Done  (Done)
`ifdef TAP_SCAN_ERR_EN
        ,
        .SelErr(SelErr)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        A = '0;
        for (int k = 0; k < N; k++) A[k*SIZE +: SIZE] = taps[k];
    end

    function automatic logic [SIZE-1:0] refWord(input int sel);
        return (sel < N) ? taps[sel] : '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit mode, input bit req, input logic [SEL_W-1:0] sel,
                                 input bit start, input bit ready);
        Mode  = mode;
        Req   = req;
        Sel   = sel;
        Start = start;
        Ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBeat(input int sel, input bit last, input bit err);
        beat_t bt;
        bt.b    = refWord(sel);
        bt.idx  = sel;
        bt.last = last;
        bt.err  = err;
        sb.push_back(bt);
    endtask

    task automatic pushScan();
        for (int k = 0; k < N; k++) pushBeat(k, k == N - 1, 1'b0);
    endtask

    task automatic setRampTaps();
        for (int k = 0; k < N; k++) taps[k] = 16'h0100 + 16'(k);
    endtask

    // Every accepted beat must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && Valid && Ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_beat_idx", 32'(Idx), 32'hFFFF_FFFF);
            end else begin
                monBeat = sb.pop_front();
                checkOutput("beat_b", 32'(B), 32'(monBeat.b));
                checkOutput("beat_idx", 32'(Idx), 32'(monBeat.idx));
                checkOutput("beat_last", 32'(Last), 32'(monBeat.last));
`ifdef TAP_SCAN_ERR_EN
                checkOutput("beat_selerr", 32'(SelErr), 32'(monBeat.err));
`endif
            end
        end
    end

    task automatic runScan(input string tag, input int stallAt, input int stallLen,
                           input bit randReady, input bit poke, input int expDone);
        int doneAt, doneCnt, stalled;
        bit stallNow;
        pushScan();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step();
        doneAt  = -1;
        doneCnt = 0;
        stalled = 0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            stallNow = 1'b0;
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, SEL_W'($urandom_range(0, N - 1)), 1'b0,
                          randReady ? 1'($urandom_range(0, 1)) : 1'b1);
            if (Valid && 32'(Idx) == stallAt && stalled < stallLen) begin
                Ready    = 1'b0;
                stalled++;
                stallNow = 1'b1;
            end
            if (poke && cyc == 5) begin
                Start = 1'b1;
                Mode  = 1'b1;
                Req   = 1'b1;
            end
            if (poke && Valid && Last) begin
                Start = 1'b1;
                Mode  = 1'b1;
                Ready = 1'b1;
            end
            @(negedge clk);
            if (stallNow) begin
                checkOutput({tag, "_hold_b"}, 32'(B), 32'(refWord(stallAt)));
                checkOutput({tag, "_hold_idx"}, 32'(Idx), 32'(stallAt));
            end
            if (expDone > 0 && cyc <= expDone + 3) begin
                checkOutput({tag, "_busy"}, 32'(Busy), 32'(cyc < expDone));
                checkOutput({tag, "_done"}, 32'(Done), 32'(cyc == expDone));
            end
            if (Done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = cyc;
            end
            step();
            if (doneAt > 0 && cyc >= doneAt + 4) break;
        end
        checkOutput({tag, "_done_count"}, 32'(doneCnt), 32'd1);
        if (expDone > 0) checkOutput({tag, "_done_cycle"}, 32'(doneAt), 32'(expDone));
        checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(Busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_b"}, 32'(B), 32'd0);
        checkOutput({tag, "_idx"}, 32'(Idx), 32'd0);
        checkOutput({tag, "_valid"}, 32'(Valid), 32'd0);
        checkOutput({tag, "_last"}, 32'(Last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(Busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(Done), 32'd0);
`ifdef TAP_SCAN_ERR_EN
        checkOutput({tag, "_selerr"}, 32'(SelErr), 32'd0);
`endif
    endtask

    initial begin
        int sel;
        bit req;
        bit found;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        setRampTaps();
        #12;
        checkAllZero("reset");
        step();
        rst = 1'b0;

        repeat (10) begin
            @(negedge clk);
            checkOutput("idle_valid", 32'(Valid), 32'd0);
            checkOutput("idle_b", 32'(B), 32'd0);
            checkOutput("idle_busy", 32'(Busy), 32'd0);
            step();
        end

        // Direct captures, in range and just out of range.
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        pushBeat(5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("direct_latency_valid", 32'(Valid), 32'd1);
        checkOutput("direct_b", 32'(B), 32'h0105);
        checkOutput("direct_busy", 32'(Busy), 32'd0);
        step();
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
        pushBeat(15, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("direct_oor_b", 32'(B), 32'd0);
        checkOutput("direct_oor_idx", 32'(Idx), 32'd15);
`ifdef TAP_SCAN_ERR_EN
        checkOutput("direct_oor_selerr", 32'(SelErr), 32'd1);
`endif
        step();

        repeat (24) begin
            sel = $urandom_range(0, N);
            req = 1'($urandom_range(0, 1));
            taps[$urandom_range(0, N - 1)] = 16'($urandom);
            applyStimulus(1'b0, req, SEL_W'(sel), 1'b0, 1'b1);
            if (req) pushBeat(sel, 1'b0, sel >= N);
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (2) step();

        setRampTaps();
        runScan("scan", -1, 0, 1'b0, 1'b0, 16);
        runScan("stall", 7, 3, 1'b0, 1'b0, 19);
        runScan("poke", -1, 0, 1'b0, 1'b1, 16);

        // Asynchronous reset in the middle of a scan.
        pushScan();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (Valid && Idx == 4'd9) found = 1'b1;
            else step();
        end
        checkOutput("rst_reach_idx9", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkAllZero("midscan_reset");
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        runScan("restart", -1, 0, 1'b0, 1'b0, 16);

        for (int k = 0; k < N; k++) taps[k] = 16'($urandom);
        runScan("rand_ready", -1, 0, 1'b1, 1'b0, -1);

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (3) step();
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
